t_flip_flop_bank: RTL

Parametrised bank of toggle-capable flip-flops: the multi-channel successor to the single-bit T flip-flop. Each of `N_CH` channels synchronises its asynchronous pin inputs, optionally edge-detects them, and updates its stored bit in T, D or JK mode. Synchronous load, a global enable and per-channel saturating transition counters are included. It sits directly behind the `ui_in`/`uio_in` pins of a Tiny Tapeout top and drives `uo_out` and `uio_out`.

---
 rtl/t_flip_flop_bank_if.sv | 27 ++
 rtl/t_flip_flop_bank.sv | 114 +++++++++++
 2 files changed

// File: rtl/t_flip_flop_bank_if.sv
// Bundled control, data and status signals of a t_flip_flop_bank instance.
// master drives the pin-side inputs; slave is the bank itself.
interface t_flip_flop_bank_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8
);
    logic                    ena;
    logic [N_CH-1:0]         t_in;
    logic [N_CH-1:0]         aux_in;
    logic [1:0]              mode;
    logic                    load;
    logic [N_CH-1:0]         load_val;
    logic                    clr_cnt;
    logic [N_CH-1:0]         q;
    logic [N_CH-1:0]         qbar;
    logic [N_CH*CNT_W-1:0]   toggle_cnt;

    modport master (
        output ena, t_in, aux_in, mode, load, load_val, clr_cnt,
        input  q, qbar, toggle_cnt
    );

    modport slave (
        input  ena, t_in, aux_in, mode, load, load_val, clr_cnt,
        output q, qbar, toggle_cnt
    );
endinterface

// File: rtl/t_flip_flop_bank.sv
// Multi-channel T/D/JK flip-flop bank with input synchronisers, optional
// edge detection, parallel load and saturating per-channel transition counters.
module t_flip_flop_bank #(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 1,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    t_flip_flop_bank_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] r_t_sync [N_CH];
    logic [SYNC_STAGES-1:0] r_a_sync [N_CH];
    logic [CNT_W-1:0]       r_cnt    [N_CH];
    logic [N_CH-1:0]        r_tp;
    logic [N_CH-1:0]        r_ap;
    logic [N_CH-1:0]        r_q;
    logic [N_CH-1:0]        w_ts;
    logic [N_CH-1:0]        w_as;
    logic [N_CH-1:0]        w_tev;
    logic [N_CH-1:0]        w_aev;
    logic [N_CH-1:0]        w_qn;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic w_qn_ch;

            // Synchronisers and previous-value registers ignore ena so that
            // events arriving while disabled are consumed, not deferred.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_t_sync[gi] <= '0;
                    r_a_sync[gi] <= '0;
                end else begin
                    r_t_sync[gi] <= {r_t_sync[gi][SYNC_STAGES-2:0], bus.t_in[gi]};
                    r_a_sync[gi] <= {r_a_sync[gi][SYNC_STAGES-2:0], bus.aux_in[gi]};
                end
            end

            assign w_ts[gi] = r_t_sync[gi][SYNC_STAGES-1];
            assign w_as[gi] = r_a_sync[gi][SYNC_STAGES-1];

            if (EDGE_MODE != 0) begin : g_edge
                assign w_tev[gi] = w_ts[gi] & ~r_tp[gi];
                assign w_aev[gi] = w_as[gi] & ~r_ap[gi];
            end else begin : g_level
                assign w_tev[gi] = w_ts[gi];
                assign w_aev[gi] = w_as[gi];
            end

            always_comb begin
                w_qn_ch = r_q[gi];
                case (bus.mode)
                    2'b00: w_qn_ch = r_q[gi] ^ w_tev[gi];
                    2'b01: w_qn_ch = w_ts[gi];
                    2'b10: begin
                        case ({w_tev[gi], w_aev[gi]})
                            2'b10:   w_qn_ch = 1'b1;
                            2'b01:   w_qn_ch = 1'b0;
                            2'b11:   w_qn_ch = ~r_q[gi];
                            default: w_qn_ch = r_q[gi];
                        endcase
                    end
                    default: w_qn_ch = r_q[gi];
                endcase
            end

            assign w_qn[gi] = w_qn_ch;

            // clr_cnt overrides everything, including a disabled bank.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt[gi] <= '0;
                end else if (bus.clr_cnt) begin
                    r_cnt[gi] <= '0;
                end else if (bus.ena && !bus.load && (w_qn[gi] != r_q[gi])
                             && (r_cnt[gi] != CNT_MAX)) begin
                    r_cnt[gi] <= r_cnt[gi] + 1'b1;
                end
            end

            assign bus.toggle_cnt[gi*CNT_W +: CNT_W] = r_cnt[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tp <= '0;
            r_ap <= '0;
        end else begin
            r_tp <= w_ts;
            r_ap <= w_as;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (bus.ena) begin
            if (bus.load) begin
                r_q <= bus.load_val;
            end else begin
                r_q <= w_qn;
            end
        end
    end

    assign bus.q    = r_q;
    assign bus.qbar = ~r_q;
endmodule
